one_hot_encoder_pipe: RTL and testbench
=======================================

Name: one_hot_encoder_pipe

Overview:
Inverse of the pipeline's one-hot decoder stage: converts an N-bit one-hot select vector back to its binary index. Registered, with a valid/ready handshake and a 2-entry skid buffer, so it can sit between pipeline stages without a combinational ready path. Flags non-one-hot inputs (zero-hot or multi-hot) and keeps a saturating error count for debug.

Parameters:
N, 8, width of one-hot input vector; power of two, N >= 2
W, 3, width of binary index output; must equal log2(N)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk  input  1  rising-edge clock; the block's only clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  upstream has a vector on `in`
in_ready  output  1  block can accept; registered
in  input  N  one-hot select vector
out_valid  output  1  `out` / `out_err` hold a result
out_ready  input  1  downstream accepts the result
out  output  W  binary index of the set bit
out_err  output  1  accompanying input was not exactly one-hot
err_count  output  ERR_CNT_W  count of accepted non-one-hot inputs, saturating
clear_err  input  1  synchronous clear of err_count

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values, taking effect on the first edge with rst=1: out_valid=0, out=0, out_err=0, in_ready=1, err_count=0, skid empty.
- Reset mid-transfer discards both held entries.
- Transfer rules:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - out, out_err and out_valid stay stable while out_valid=1 and out_ready=0.
- Encoding, evaluated on the accepted `in`:
  - exactly one bit k set -> out=k, out_err=0
  - zero bits set -> out=0, out_err=1
  - multi-hot -> out = index of the lowest set bit, out_err=1
- Latency: exactly 1 cycle from accept to out_valid when the output register is empty or draining. Throughput is 1 per cycle when out_ready stays high.
- Storage is two entries: output register (main) plus skid.
  - Accept, main empty or draining this cycle -> result loads main.
  - Accept, main full and not draining -> result loads skid; in_ready goes 0 next cycle.
  - Main drains while skid full -> skid moves to main; in_ready returns to 1 next cycle.
  - in_ready = !skid_full, registered. An input offered while in_ready=0 is ignored and must be held by upstream.
  - No entry is ever dropped or duplicated.
- err_count:
  - +1 for each accepted input whose out_err=1; counts at accept, not at output transfer.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - clear_err=1 sets the count to 0 next cycle and wins over a simultaneous increment, so that error is not counted.
  - rst has priority over everything.
- in_valid=0 never changes held data.

Decomposition:
- Shared package one_hot_pkg holds:
  - N/W default constants
  - a function onehot_to_index(vec) returning {err, index}, using lowest-set-bit priority
  - the zero-hot and multi-hot error encodings
- The existing decoder stage also reuses this package for its N/W constants.
- Sub-module ohe_skid_buf: a generic 2-entry skid buffer with payload width W+1, carrying {out_err, out}. The top level does the encode function, the error counter and the wiring.

Test Plan:
- Reset and single accept: assert rst for 2 cycles -> out_valid=0, in_ready=1, err_count=0. Then in=8'b0010_0000, in_valid=1 with out_ready=1 -> next cycle out=5, out_err=0, out_valid=1.
- Full sweep: with out_ready=1, drive in=1<<k for k=0..7 on consecutive cycles -> out = 0..7 on consecutive cycles with no bubbles, out_err always 0.
- Error cases:
  - in=8'h00 -> out=0, out_err=1
  - in=8'b0100_1100 -> out=2, out_err=1
  - after both, err_count=2
- Backpressure:
  - hold out_ready=0 and push 1<<3 then 1<<6 -> in_ready=0 after the second accept; out stays 3.
  - release out_ready -> outputs 3 then 6, in_ready=1; a third vector offered during stall is not lost.
- Counter: with ERR_CNT_W=8, feed 260 zero-hot vectors -> err_count=255. Then assert clear_err in the same cycle as an accepted error -> err_count=0.
- Reset mid-operation: skid full, assert rst -> next cycle out_valid=0, in_ready=1. No stale output is produced afterwards.

Source files
------------

// File: rtl/one_hot_pkg.sv
// Shared constants and encode helpers for the one-hot decode/encode pipeline stages.
package one_hot_pkg;

    localparam int N_DEF     = 8;
    localparam int W_DEF     = 3;
    localparam int IDX_MAX_N = 64;
    localparam int IDX_MAX_W = 6;

    typedef enum logic [1:0] {
        ENC_ONE_HOT   = 2'd0,
        ENC_ZERO_HOT  = 2'd1,
        ENC_MULTI_HOT = 2'd2
    } enc_status_e;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_MAIN  = 2'd1,
        S_FULL  = 2'd2
    } skid_state_e;

    function automatic enc_status_e onehot_status(input logic [IDX_MAX_N-1:0] vec);
        int unsigned ones;
        ones = 0;
        for (int i = 0; i < IDX_MAX_N; i++) begin
            if (vec[i]) ones++;
        end
        if (ones == 0)      return ENC_ZERO_HOT;
        else if (ones == 1) return ENC_ONE_HOT;
        else                return ENC_MULTI_HOT;
    endfunction

    // Returns {err, index}; the lowest set bit wins, an all-zero vector gives index 0.
    function automatic logic [IDX_MAX_W:0] onehot_to_index(input logic [IDX_MAX_N-1:0] vec);
        logic [IDX_MAX_W-1:0] idx;
        logic                 found;
        logic                 multi;
        idx   = '0;
        found = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < IDX_MAX_N; i++) begin
            if (vec[i]) begin
                if (!found) idx = i[IDX_MAX_W-1:0];
                else        multi = 1'b1;
                found = 1'b1;
            end
        end
        return {(!found) | multi, idx};
    endfunction

endpackage

// File: rtl/ohe_skid_buf.sv
// Two-entry skid buffer: registered output stage plus one spill slot, registered in_ready.
//
// state   | meaning
// S_EMPTY | nothing held, out_valid=0
// S_MAIN  | output register holds an entry, skid empty
// S_FULL  | output register and skid both hold entries, in_ready=0
module ohe_skid_buf
    import one_hot_pkg::*;
#(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    skid_state_e   state;
    logic [DW-1:0] skid_data;
    logic          accept;
    logic          drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        out_data  <= in_data;
                        out_valid <= 1'b1;
                        state     <= S_MAIN;
                    end
                end
                S_MAIN: begin
                    if (accept && !drain) begin
                        skid_data <= in_data;
                        in_ready  <= 1'b0;
                        state     <= S_FULL;
                    end else if (accept) begin
                        out_data <= in_data;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                        state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so no new entry can arrive this cycle
                    if (drain) begin
                        out_data <= skid_data;
                        in_ready <= 1'b1;
                        state    <= S_MAIN;
                    end
                end
                default: begin
                    state     <= S_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/one_hot_encoder_pipe.sv
// One-hot to binary index encoder with valid/ready skid buffering and a saturating error counter.
module one_hot_encoder_pipe
    import one_hot_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int W         = W_DEF,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count,
    input  logic                 clear_err
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    if (N < 2 || (N & (N - 1)) != 0 || N > IDX_MAX_N || W != $clog2(N)) begin : g_bad_param
        $error("one_hot_encoder_pipe: N must be a power of two in 2..64 and W must be log2(N)");
    end

    logic [IDX_MAX_N-1:0] in_ext;
    logic [IDX_MAX_W:0]   enc;
    logic                 enc_err;
    logic [W-1:0]         enc_idx;
    logic                 accept;

    assign in_ext  = IDX_MAX_N'(in);
    assign enc     = onehot_to_index(in_ext);
    assign enc_idx = enc[W-1:0];

    // Index bits above W are always zero for a zero-extended input; folding them in keeps them live.
    if (W < IDX_MAX_W) begin : g_fold
        assign enc_err = enc[IDX_MAX_W] | (|enc[IDX_MAX_W-1:W]);
    end else begin : g_nofold
        assign enc_err = enc[IDX_MAX_W];
    end

    assign accept = in_valid & in_ready;

    ohe_skid_buf #(
        .DW(W + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({enc_err, enc_idx}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_err, out})
    );

    // Errors are counted at accept time; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (clear_err) begin
            err_count <= '0;
        end else if (accept && enc_err && err_count != ERR_MAX) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_one_hot_encoder_pipe.sv
// Directed bench for one_hot_encoder_pipe: reset, sweep, error encodings, backpressure, counter, mid-run reset.
module tb_one_hot_encoder_pipe;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out;
    logic       out_err;
    logic [7:0] err_count;
    logic       clear_err;

    int n_checks = 0;
    int n_pass   = 0;

    one_hot_encoder_pipe #(
        .N(8),
        .W(3),
        .ERR_CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in       (in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .out_err  (out_err),
        .err_count(err_count),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Advance one edge, then settle so outputs reflect that edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in        = 8'h00;
        out_ready = 1'b0;
        clear_err = 1'b0;

        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_out",       32'(out),       0);
        chk("rst_out_err",   32'(out_err),   0);

        rst       = 1'b0;
        in        = 8'b0010_0000;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_out",   32'(out),       5);
        chk("single_err",   32'(out_err),   0);

        for (int k = 0; k < 8; k++) begin
            in = 8'(1 << k);
            step();
            chk($sformatf("sweep_valid_%0d", k), 32'(out_valid), 1);
            chk($sformatf("sweep_out_%0d", k),   32'(out),       32'(k));
            chk($sformatf("sweep_err_%0d", k),   32'(out_err),   0);
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drained", 32'(out_valid), 0);

        in       = 8'h00;
        in_valid = 1'b1;
        step();
        chk("zero_out", 32'(out),     0);
        chk("zero_err", 32'(out_err), 1);
        in = 8'b0100_1100;
        step();
        chk("multi_out", 32'(out),     2);
        chk("multi_err", 32'(out_err), 1);
        in_valid = 1'b0;
        step();
        chk("err_count_2", 32'(err_count), 2);
        chk("err_drained", 32'(out_valid), 0);

        out_ready = 1'b0;
        in        = 8'(1 << 3);
        in_valid  = 1'b1;
        step();
        chk("bp_first_out",   32'(out),      3);
        chk("bp_first_ready", 32'(in_ready), 1);
        in = 8'(1 << 6);
        step();
        chk("bp_second_ready", 32'(in_ready),  0);
        chk("bp_second_out",   32'(out),       3);
        chk("bp_second_valid", 32'(out_valid), 1);
        in = 8'(1 << 1);
        step();
        chk("bp_stall_ready", 32'(in_ready), 0);
        chk("bp_stall_out",   32'(out),      3);
        out_ready = 1'b1;
        step();
        chk("bp_rel_out",   32'(out),       6);
        chk("bp_rel_ready", 32'(in_ready),  1);
        chk("bp_rel_valid", 32'(out_valid), 1);
        step();
        chk("bp_third_out",   32'(out),       1);
        chk("bp_third_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        step();
        chk("bp_drained",   32'(out_valid), 0);
        chk("bp_err_count", 32'(err_count), 2);

        in       = 8'h00;
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) step();
        in_valid = 1'b0;
        step();
        chk("sat_count", 32'(err_count), 255);

        in_valid  = 1'b1;
        clear_err = 1'b1;
        step();
        chk("clear_count", 32'(err_count), 0);
        clear_err = 1'b0;
        in_valid  = 1'b0;
        step();
        chk("clear_hold", 32'(err_count), 0);
        in_valid = 1'b1;
        step();
        chk("count_after_clear", 32'(err_count), 1);
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        in        = 8'(1 << 4);
        in_valid  = 1'b1;
        step();
        in = 8'(1 << 7);
        step();
        chk("mid_skid_full", 32'(in_ready), 0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready),  1);
        chk("mid_rst_count", 32'(err_count), 0);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_no_stale_%0d", i), 32'(out_valid), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
